// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with flush, head presented from storage registers.
// Latency: a pushed entry is at the head the cycle after the push when empty.
// Backpressure: push is dropped when full unless a pop frees the slot the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: run/idle FSM and PC, feeding {pc, instr} pairs into a prefetch queue.
// Latency: one cycle from fetch to queue head; redirect costs two cycles to first instruction.
// Backpressure: fetch stalls when the queue is full and the head is not being consumed.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic [WIDTH-1:0]       imem_rd,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_instr,
    output logic [WIDTH-1:0]       out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   pc;
    logic               fetch;
    logic               pop;
    logic [2*WIDTH-1:0] head;
    logic               unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect squashes both the fetch and any pop in its cycle.
    always_comb begin
        state_nxt = run ? FETCH : IDLE;
        pop       = out_valid && out_ready && !redirect;
        fetch     = 1'b0;
        if (state == FETCH && run && !redirect && ((count != CW'(DEPTH)) || pop)) begin
            fetch = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (fetch) begin
            pc <= pc + WIDTH'(WORD_BYTES);
        end
    end

    fetch_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect),
        .din   ({pc, imem_rd}),
        .dout  (head),
        .count (count)
    );

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = head[2*WIDTH-1:WIDTH];
    assign out_instr = head[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, corner sequences, then randomized run against a queue scoreboard.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    assign imem_rd = memword(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        run;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        int          cnt;
        logic [31:0] addr;
        logic        chk_data;
        logic [31:0] opc;
        logic [31:0] oinstr;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rn, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input int cnt, input logic [31:0] addr,
                                input logic cd, input logic [31:0] opc, input logic [31:0] oi);
        vec_t v;
        v.rst = rst; v.run = rn; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
        v.cnt = cnt; v.addr = addr; v.chk_data = cd; v.opc = opc; v.oinstr = oi;
        return v;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb_q[$];
    logic [31:0] m_pc;
    logic        m_fetching;

    // Reference behaviour at one rising edge, using the inputs held across it.
    task automatic model_update();
        logic mvalid, mpop, mfetch;
        if (reset) begin
            m_fetching = 1'b0;
            m_pc       = 32'h0;
            sb_q.delete();
        end else begin
            mvalid = (sb_q.size() != 0);
            mpop   = mvalid && out_ready && !redirect;
            mfetch = m_fetching && run && !redirect && ((sb_q.size() < 4) || mpop);
            if (redirect) begin
                sb_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (mpop) void'(sb_q.pop_front());
                if (mfetch) begin
                    sb_q.push_back({m_pc, memword(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_fetching = run;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic rn, input logic rd, input logic [31:0] rpc, input logic rdy);
        reset = rst; run = rn; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    endtask

    vec_t vecs[$];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Streaming, fill/hold, full-with-pop, idle drain, redirect.
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 32'h0,   1, 32'h0,   32'h0));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 32'h0,   0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0,      1, 1, 32'h4,   1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      1, 1, 32'h8,   1, 32'h4,   32'h22));
        vecs.push_back(mk(0, 1, 0, 0,      1, 1, 32'hC,   1, 32'h8,   32'h33));
        vecs.push_back(mk(0, 1, 0, 0,      1, 1, 32'h10,  1, 32'hC,   32'h44));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 32'h0,   1, 32'h0,   32'h0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 32'h0,   0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 1, 32'h4,   1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      0, 2, 32'h8,   1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      0, 3, 32'hC,   1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      0, 4, 32'h10,  1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      0, 4, 32'h10,  1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      0, 4, 32'h10,  1, 32'h0,   32'h11));
        vecs.push_back(mk(0, 1, 0, 0,      1, 4, 32'h14,  1, 32'h4,   32'h22));
        vecs.push_back(mk(0, 0, 0, 0,      1, 3, 32'h14,  1, 32'h8,   32'h33));
        vecs.push_back(mk(0, 1, 1, 32'h103, 1, 0, 32'h100, 0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 1, 32'h104, 1, 32'h100, memword(32'h100)));
        vecs.push_back(mk(0, 0, 0, 0,      1, 0, 32'h104, 0, 0,       0));
        vecs.push_back(mk(0, 0, 0, 0,      1, 0, 32'h104, 0, 0,       0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            step();
            check($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("row%0d valid", i), 32'(out_valid), 32'(vecs[i].cnt != 0));
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
            if (vecs[i].chk_data) begin
                check($sformatf("row%0d out_pc", i), out_pc, vecs[i].opc);
                check($sformatf("row%0d out_instr", i), out_instr, vecs[i].oinstr);
            end
        end

        // PC wrap at the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFFF, 0);
        step();
        check("wrap redirect addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 1, 0, 32'h0, 0);
        step();
        check("wrap addr", imem_addr, 32'h0);
        check("wrap out_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap out_instr", out_instr, memword(32'hFFFF_FFFC));
        step();
        check("wrap count", 32'(count), 32'd2);
        check("wrap addr2", imem_addr, 32'h4);

        // Reset beats redirect with entries queued.
        drive(1, 1, 1, 32'h200, 1);
        step();
        check("rst count", 32'(count), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst addr", imem_addr, 32'h0);
        check("rst out_pc", out_pc, 32'h0);
        check("rst out_instr", out_instr, 32'h0);
        drive(0, 1, 0, 32'h0, 1);
        step();
        check("rst idle count", 32'(count), 32'd0);
        check("rst idle addr", imem_addr, 32'h0);

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            drive((c == 0) || ($urandom_range(0, 99) < 2),
                  $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 6,
                  32'($urandom_range(0, 1023)),
                  $urandom_range(0, 1));
            @(posedge clk);
            model_update();
            @(negedge clk);
            check($sformatf("rnd%0d count", c), 32'(count), 32'(sb_q.size()));
            check($sformatf("rnd%0d valid", c), 32'(out_valid), 32'(sb_q.size() != 0));
            check($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
            if (sb_q.size() != 0) begin
                check($sformatf("rnd%0d out_pc", c), out_pc, sb_q[0].pc);
                check($sformatf("rnd%0d out_instr", c), out_instr, sb_q[0].instr);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
